mar_burst: RTL and testbench

Parametrised successor to the memory address register. It holds an address wider than the bus and loads it one bus-width half at a time. It supports single-step increment and decrement, plus a self-timed auto-increment burst mode for block transfers. It sits between the system bus and the RAM address inputs, drives the RAM address directly, and flags wrap-around and burst completion to the control sequencer.

---
 rtl/mar_burst.sv | 137 +++++++++++++
 tb/tb_mar_burst.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mar_burst.sv
// mar_burst: memory address register wider than the bus, loaded one half at a
// time, with single-step increment/decrement and a self-timed burst mode that
// walks the address for block transfers. Flags wrap-around and burst end.
//
// Handshake: there is no valid/ready pair. Every control is sampled once per
// rising clock edge, and every output is a register that updates on that same
// edge. i_STALL freezes an active burst on each cycle it is high. o_DONE and
// o_WRAP are single-cycle pulses.
module mar_burst #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 4,
  parameter int BURST_WIDTH   = 3
) (
  input  logic                     i_CLOCK,
  input  logic                     i_CLEAR,
  input  logic [BUS_WIDTH-1:0]     i_BUS,
  input  logic                     i_LOAD_LO_n,
  input  logic                     i_LOAD_HI_n,
  input  logic                     i_INC_n,
  input  logic                     i_DEC_n,
  input  logic                     i_BURST_n,
  input  logic                     i_STALL,
  input  logic                     i_ABORT_n,
  output logic [ADDRESS_WIDTH-1:0] o_DATA,
  output logic                     o_BUSY,
  output logic [BURST_WIDTH-1:0]   o_REMAINING,
  output logic                     o_DONE,
  output logic                     o_WRAP
);

  // Width of the upper address half that is loaded from the low bus bits.
  localparam int HI_WIDTH = ADDRESS_WIDTH - BUS_WIDTH;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONES = '1;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ZERO = '0;
  localparam logic [BURST_WIDTH-1:0]   REM_ONE   = BURST_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0]   REM_ZERO  = '0;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] addr, addr_next;
  logic [BURST_WIDTH-1:0]   remaining, remaining_next;
  logic                     done, done_next;
  logic                     wrap, wrap_next;
  logic [BURST_WIDTH-1:0]   burst_len;

  assign burst_len = i_BUS[BURST_WIDTH-1:0];

  // State and output registers; reset clears everything, including a burst in
  // flight, without raising o_DONE.
  always_ff @(posedge i_CLOCK or posedge i_CLEAR) begin
    if (i_CLEAR) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_next;
      addr      <= addr_next;
      remaining <= remaining_next;
      done      <= done_next;
      wrap      <= wrap_next;
    end
  end

  // Next-state and next-output decode: loads beat burst start beats stepping
  // in IDLE; abort beats stall in BURST.
  always_comb begin
    state_next     = state;
    addr_next      = addr;
    remaining_next = remaining;
    done_next      = 1'b0;
    wrap_next      = 1'b0;

    case (state)
      IDLE: begin
        if (!i_LOAD_LO_n || !i_LOAD_HI_n) begin
          if (!i_LOAD_LO_n) begin
            addr_next[BUS_WIDTH-1:0] = i_BUS;
          end
          if (!i_LOAD_HI_n) begin
            addr_next[ADDRESS_WIDTH-1:BUS_WIDTH] = i_BUS[HI_WIDTH-1:0];
          end
        end else if (!i_BURST_n) begin
          // A zero-length burst is a silent no-op.
          if (burst_len != REM_ZERO) begin
            state_next     = BURST;
            remaining_next = burst_len;
          end
        end else if (!i_INC_n && i_DEC_n) begin
          addr_next = addr + ADDR_ONE;
          wrap_next = (addr == ADDR_ONES);
        end else if (i_INC_n && !i_DEC_n) begin
          addr_next = addr - ADDR_ONE;
          wrap_next = (addr == ADDR_ZERO);
        end
      end

      BURST: begin
        if (!i_ABORT_n) begin
          state_next     = IDLE;
          remaining_next = '0;
          done_next      = 1'b1;
        end else if (i_STALL) begin
          // Hold everything while the consumer is not ready.
          state_next = BURST;
        end else if (remaining == REM_ONE) begin
          // The final beat keeps its address; the burst ends here.
          state_next     = IDLE;
          remaining_next = '0;
          done_next      = 1'b1;
        end else begin
          addr_next      = addr + ADDR_ONE;
          remaining_next = remaining - REM_ONE;
          wrap_next      = (addr == ADDR_ONES);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_DATA      = addr;
  assign o_BUSY      = (state == BURST);
  assign o_REMAINING = remaining;
  assign o_DONE      = done;
  assign o_WRAP      = wrap;

endmodule

// File: tb/tb_mar_burst.sv
// Directed bench for mar_burst with the default 8/4/3 geometry. Inputs change
// 1 time unit after a rising edge; outputs are checked at that same point.
module tb_mar_burst;

  logic       clk;
  logic       clr;
  logic [3:0] bus;
  logic       load_lo_n, load_hi_n, inc_n, dec_n, burst_n, stall, abort_n;
  logic [7:0] data;
  logic       busy;
  logic [2:0] remaining;
  logic       done;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  mar_burst #(
    .ADDRESS_WIDTH(8),
    .BUS_WIDTH(4),
    .BURST_WIDTH(3)
  ) dut (
    .i_CLOCK    (clk),
    .i_CLEAR    (clr),
    .i_BUS      (bus),
    .i_LOAD_LO_n(load_lo_n),
    .i_LOAD_HI_n(load_hi_n),
    .i_INC_n    (inc_n),
    .i_DEC_n    (dec_n),
    .i_BURST_n  (burst_n),
    .i_STALL    (stall),
    .i_ABORT_n  (abort_n),
    .o_DATA     (data),
    .o_BUSY     (busy),
    .o_REMAINING(remaining),
    .o_DONE     (done),
    .o_WRAP     (wrap)
  );

  // Clock and reset: 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison point: counts the check, and counts and reports a failure.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check all five outputs at once.
  task automatic chk_all(input string tag, input logic [7:0] e_data, input logic e_busy,
                         input logic [2:0] e_rem, input logic e_done, input logic e_wrap);
    chk({tag, ".data"}, 32'(data), 32'(e_data));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".rem"},  32'(remaining), 32'(e_rem));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".wrap"}, 32'(wrap), 32'(e_wrap));
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_lo_n = 1'b1; load_hi_n = 1'b1; inc_n = 1'b1; dec_n = 1'b1;
    burst_n = 1'b1; stall = 1'b0; abort_n = 1'b1; bus = 4'h0;
  endtask

  // Driver tasks: each applies a control for one edge then releases it.
  task automatic load_lo(input logic [3:0] v);
    bus = v; load_lo_n = 1'b0; tick(); idle_inputs();
  endtask

  task automatic load_hi(input logic [3:0] v);
    bus = v; load_hi_n = 1'b0; tick(); idle_inputs();
  endtask

  task automatic load_addr(input logic [7:0] a);
    load_lo(a[3:0]);
    load_hi(a[7:4]);
  endtask

  task automatic start_burst(input logic [3:0] n);
    bus = n; burst_n = 1'b0; tick(); idle_inputs();
  endtask

  initial begin
    idle_inputs();
    clr = 1'b1;
    #12;
    // Reset held across edges.
    chk_all("reset", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    chk_all("reset_hold", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    clr = 1'b0;

    // Half loads on separate edges, then both halves together.
    load_lo(4'hA);
    chk("load_lo", 32'(data), 32'h0A);
    load_hi(4'h5);
    chk("load_hi", 32'(data), 32'h5A);
    bus = 4'h3; load_lo_n = 1'b0; load_hi_n = 1'b0; tick(); idle_inputs();
    chk("load_both", 32'(data), 32'h33);

    // Load takes priority over inc in the same cycle.
    bus = 4'hF; load_lo_n = 1'b0; load_hi_n = 1'b0; inc_n = 1'b0; tick(); idle_inputs();
    chk_all("load_ff", 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0);

    // Step increment wraps FF -> 00, decrement wraps back.
    inc_n = 1'b0; tick(); idle_inputs();
    chk_all("inc_wrap", 8'h00, 1'b0, 3'd0, 1'b0, 1'b1);
    tick();
    chk("inc_wrap_pulse_end", 32'(wrap), 32'h0);
    dec_n = 1'b0; tick(); idle_inputs();
    chk_all("dec_wrap", 8'hFF, 1'b0, 3'd0, 1'b0, 1'b1);
    tick();
    chk("dec_wrap_pulse_end", 32'(wrap), 32'h0);
    inc_n = 1'b0; dec_n = 1'b0; tick(); idle_inputs();
    chk_all("inc_dec_both", 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0);
    // Non-wrapping decrement.
    dec_n = 1'b0; tick(); idle_inputs();
    chk_all("dec_plain", 8'hFE, 1'b0, 3'd0, 1'b0, 1'b0);
    // Stall and abort have no effect while idle.
    stall = 1'b1; abort_n = 1'b0; tick(); idle_inputs();
    chk_all("idle_stall_abort", 8'hFE, 1'b0, 3'd0, 1'b0, 1'b0);

    // Burst of 4 from 0x10.
    load_addr(8'h10);
    start_burst(4'h4);
    chk_all("b4_beat0", 8'h10, 1'b1, 3'd4, 1'b0, 1'b0);
    tick();
    chk_all("b4_beat1", 8'h11, 1'b1, 3'd3, 1'b0, 1'b0);
    tick();
    chk_all("b4_beat2", 8'h12, 1'b1, 3'd2, 1'b0, 1'b0);
    tick();
    chk_all("b4_beat3", 8'h13, 1'b1, 3'd1, 1'b0, 1'b0);
    tick();
    chk_all("b4_done", 8'h13, 1'b0, 3'd0, 1'b1, 1'b0);
    tick();
    chk_all("b4_after", 8'h13, 1'b0, 3'd0, 1'b0, 1'b0);

    // Burst of 3 from 0xFE with a one-cycle stall and a wrap.
    load_addr(8'hFE);
    start_burst(4'h3);
    chk_all("b3_c1", 8'hFE, 1'b1, 3'd3, 1'b0, 1'b0);
    tick();
    chk_all("b3_c2", 8'hFF, 1'b1, 3'd2, 1'b0, 1'b0);
    stall = 1'b1; tick(); idle_inputs();
    chk_all("b3_c3_stalled", 8'hFF, 1'b1, 3'd2, 1'b0, 1'b0);
    tick();
    chk_all("b3_c4_wrap", 8'h00, 1'b1, 3'd1, 1'b0, 1'b1);
    tick();
    chk_all("b3_done", 8'h00, 1'b0, 3'd0, 1'b1, 1'b0);

    // Burst of 7 from 0x20: ignored controls, then abort.
    load_addr(8'h20);
    start_burst(4'h7);
    chk_all("b7_c1", 8'h20, 1'b1, 3'd7, 1'b0, 1'b0);
    tick();
    chk_all("b7_c2", 8'h21, 1'b1, 3'd6, 1'b0, 1'b0);
    bus = 4'h9; inc_n = 1'b0; load_lo_n = 1'b0; tick(); idle_inputs();
    chk_all("b7_c3_ignored", 8'h22, 1'b1, 3'd5, 1'b0, 1'b0);
    abort_n = 1'b0; stall = 1'b1; tick(); idle_inputs();
    chk_all("b7_abort", 8'h22, 1'b0, 3'd0, 1'b1, 1'b0);

    // Zero-length burst; bus 0x8 has zero in the low three bits.
    start_burst(4'h8);
    chk_all("b0_noop", 8'h22, 1'b0, 3'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-burst.
    start_burst(4'h5);
    chk_all("b5_c1", 8'h22, 1'b1, 3'd5, 1'b0, 1'b0);
    tick();
    chk_all("b5_c2", 8'h23, 1'b1, 3'd4, 1'b0, 1'b0);
    #2;
    clr = 1'b1;
    #1;
    chk_all("async_clr", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    chk_all("async_clr_hold", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    clr = 1'b0;
    inc_n = 1'b0; tick(); idle_inputs();
    chk_all("post_clr_inc", 8'h01, 1'b0, 3'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
